// File: rtl/ps2_kbd_poller.sv
// APB master that polls the PS/2 keyboard slave, assembles E0/F0-prefixed scan codes
// into key events and queues them in a small FIFO. Optional macro: PS2_POLL_TIMEOUT_EN.
module ps2_kbd_poller #(
    parameter logic [31:0] PS2_ADDR      = 32'h1001_1000,
    parameter int          POLL_INTERVAL = 64,
    parameter int          EVT_DEPTH     = 8,
    parameter int          TIMEOUT       = 256
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           enable,
    output logic [31:0]                    m_paddr,
    output logic                           m_psel,
    output logic                           m_penable,
    output logic                           m_pwrite,
    output logic [31:0]                    m_pwdata,
    output logic [3:0]                     m_pstrb,
    output logic [2:0]                     m_pprot,
    input  logic                           m_pready,
    input  logic [31:0]                    m_prdata,
    input  logic                           m_pslverr,
    output logic                           evt_valid,
    input  logic                           evt_ready,
    output logic [9:0]                     evt_data,
    output logic [$clog2(EVT_DEPTH+1)-1:0] evt_count,
    output logic                           err_flag,
    input  logic                           err_clr,
    output logic [1:0]                     dbg_apb_state,
    output logic [1:0]                     dbg_parse_state
);

    localparam int CW = $clog2(EVT_DEPTH + 1);
    localparam int PW = $clog2(EVT_DEPTH);
    localparam int TW = $clog2(POLL_INTERVAL + 1);

    typedef enum logic [1:0] {
        A_IDLE   = 2'd0,
        A_SETUP  = 2'd1,
        A_ACCESS = 2'd2
    } apb_state_t;

    typedef enum logic [1:0] {
        P_IDLE = 2'd0,
        P_E0   = 2'd1,
        P_F0   = 2'd2,
        P_E0F0 = 2'd3
    } parse_state_t;

    apb_state_t   r_apb_state;
    apb_state_t   w_apb_next;
    parse_state_t r_parse_state;
    parse_state_t w_parse_next;

    logic [TW-1:0] r_timer;
    logic          r_push_pend;
    logic [9:0]    r_push_data;
    logic [9:0]    r_mem [EVT_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_err_flag;

    logic       w_done;
    logic       w_abort;
    logic       w_start;
    logic       w_room;
    logic       w_accept;
    logic       w_pop;
    logic       w_push_req;
    logic [9:0] w_push_evt;
    logic [7:0] w_byte;
    logic [23:0] w_unused_prdata;

    assign w_byte          = m_prdata[7:0];
    assign w_unused_prdata = m_prdata[31:8];
    assign w_done          = (r_apb_state == A_ACCESS) && m_pready;
    assign w_accept        = w_done && !m_pslverr && (w_byte != 8'h00);
    // A pending push counts as occupied so an in-flight event always has a slot.
    assign w_room          = (32'(r_count) + 32'(r_push_pend)) < 32'(EVT_DEPTH);
    assign w_start         = (r_apb_state == A_IDLE) && enable && (r_timer == '0) && w_room;
    assign w_pop           = (r_count != '0) && evt_ready;

`ifdef PS2_POLL_TIMEOUT_EN
    localparam int OW = $clog2(TIMEOUT + 1);
    logic [OW-1:0] r_to_cnt;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_to_cnt <= '0;
        end else if (r_apb_state != A_ACCESS) begin
            r_to_cnt <= '0;
        end else if (!m_pready) begin
            r_to_cnt <= r_to_cnt + OW'(1);
        end
    end

    assign w_abort = (r_apb_state == A_ACCESS) && !m_pready && (r_to_cnt == OW'(TIMEOUT - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT > 0);
    assign w_abort          = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_apb_state   <= A_IDLE;
            r_parse_state <= P_IDLE;
        end else begin
            r_apb_state   <= w_apb_next;
            r_parse_state <= w_parse_next;
        end
    end

    always_comb begin
        w_apb_next = r_apb_state;
        case (r_apb_state)
            A_IDLE:   if (w_start) w_apb_next = A_SETUP;
            A_SETUP:  w_apb_next = A_ACCESS;
            A_ACCESS: if (m_pready || w_abort) w_apb_next = A_IDLE;
            default:  w_apb_next = A_IDLE;
        endcase
    end

    always_comb begin
        w_parse_next = r_parse_state;
        w_push_req   = 1'b0;
        w_push_evt   = {2'b00, w_byte};
        if (w_abort) begin
            w_parse_next = P_IDLE;
        end else if (w_accept) begin
            case (r_parse_state)
                P_IDLE: begin
                    if (w_byte == 8'hE0) w_parse_next = P_E0;
                    else if (w_byte == 8'hF0) w_parse_next = P_F0;
                    else if (w_byte != 8'hE1) w_push_req = 1'b1;
                end
                P_E0: begin
                    if (w_byte == 8'hF0) begin
                        w_parse_next = P_E0F0;
                    end else if (w_byte != 8'hE0) begin
                        w_push_req   = 1'b1;
                        w_push_evt   = {2'b01, w_byte};
                        w_parse_next = P_IDLE;
                    end
                end
                P_F0: begin
                    w_parse_next = P_IDLE;
                    w_push_req   = (w_byte != 8'hE0) && (w_byte != 8'hF0);
                    w_push_evt   = {2'b10, w_byte};
                end
                default: begin
                    w_parse_next = P_IDLE;
                    w_push_req   = (w_byte != 8'hE0) && (w_byte != 8'hF0);
                    w_push_evt   = {2'b11, w_byte};
                end
            endcase
        end
    end

    // The timer is loaded one short because the cycle it reads zero is itself idle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_timer <= '0;
        end else if ((w_done && (m_pslverr || (w_byte == 8'h00))) || w_abort) begin
            r_timer <= TW'(POLL_INTERVAL - 1);
        end else if ((r_apb_state == A_IDLE) && (r_timer != '0)) begin
            r_timer <= r_timer - TW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_push_pend <= 1'b0;
            r_push_data <= '0;
        end else begin
            r_push_pend <= w_push_req;
            r_push_data <= w_push_evt;
        end
    end

    always_ff @(posedge clock) begin
        if (r_push_pend) r_mem[r_wr_ptr] <= r_push_data;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (r_push_pend) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            if (r_push_pend && !w_pop) r_count <= r_count + CW'(1);
            else if (!r_push_pend && w_pop) r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_err_flag <= 1'b0;
        end else if ((w_done && m_pslverr) || w_abort) begin
            r_err_flag <= 1'b1;
        end else if (err_clr) begin
            r_err_flag <= 1'b0;
        end
    end

    assign m_paddr         = PS2_ADDR;
    assign m_psel          = (r_apb_state != A_IDLE);
    assign m_penable       = (r_apb_state == A_ACCESS);
    assign m_pwrite        = 1'b0;
    assign m_pwdata        = '0;
    assign m_pstrb         = '0;
    assign m_pprot         = '0;
    assign evt_valid       = (r_count != '0);
    assign evt_data        = r_mem[r_rd_ptr];
    assign evt_count       = r_count;
    assign err_flag        = r_err_flag;
    assign dbg_apb_state   = r_apb_state;
    assign dbg_parse_state = r_parse_state;

endmodule

// File: tb/tb_ps2_kbd_poller.sv
// Bench for ps2_kbd_poller: scripted APB slave, scan-code vector table, randomized
// byte streams scored against a prefix-tracking event model.
module tb_ps2_kbd_poller;

    localparam logic [31:0] PS2_ADDR      = 32'h1001_1000;
    localparam int          POLL_INTERVAL = 64;
    localparam int          EVT_DEPTH     = 8;
    localparam int          TIMEOUT       = 256;
    localparam int          CW            = $clog2(EVT_DEPTH + 1);

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic [31:0]   m_paddr;
    logic          m_psel;
    logic          m_penable;
    logic          m_pwrite;
    logic [31:0]   m_pwdata;
    logic [3:0]    m_pstrb;
    logic [2:0]    m_pprot;
    logic          m_pready = 1'b0;
    logic [31:0]   m_prdata = '0;
    logic          m_pslverr = 1'b0;
    logic          evt_valid;
    logic          evt_ready = 1'b0;
    logic [9:0]    evt_data;
    logic [CW-1:0] evt_count;
    logic          err_flag;
    logic          err_clr = 1'b0;
    logic [1:0]    dbg_apb_state;
    logic [1:0]    dbg_parse_state;

    ps2_kbd_poller #(
        .PS2_ADDR(PS2_ADDR), .POLL_INTERVAL(POLL_INTERVAL),
        .EVT_DEPTH(EVT_DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable),
        .m_paddr(m_paddr), .m_psel(m_psel), .m_penable(m_penable),
        .m_pwrite(m_pwrite), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb), .m_pprot(m_pprot),
        .m_pready(m_pready), .m_prdata(m_prdata), .m_pslverr(m_pslverr),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
        .evt_count(evt_count), .err_flag(err_flag), .err_clr(err_clr),
        .dbg_apb_state(dbg_apb_state), .dbg_parse_state(dbg_parse_state)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Slave model: entries are {pslverr, byte}; an empty queue reads as zero.
    logic [8:0] slv_q[$];
    int         slv_wait_lo = 0;
    int         slv_wait_hi = 0;
    int         slv_wait = 0;
    bit         slv_busy = 0;
    bit         slv_hang = 0;

    logic [9:0] exp_q[$];
    bit         m_ext = 0;
    bit         m_brk = 0;

    typedef struct {
        logic [31:0] bytes;
        int          n;
        logic [9:0]  exp;
        string       name;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [8:0] ent;
        forever begin
            @(posedge clock);
            #1;
            if (m_psel && m_penable && !slv_hang) begin
                if (!slv_busy) begin
                    slv_busy = 1;
                    slv_wait = int'($urandom_range(slv_wait_hi, slv_wait_lo));
                end
                if (slv_wait > 0) begin
                    slv_wait--;
                    m_pready = 0; m_prdata = '0; m_pslverr = 0;
                end else begin
                    m_pready = 1;
                    if (slv_q.size() > 0) begin
                        ent = slv_q.pop_front();
                        m_prdata = {4{ent[7:0]}};
                        m_pslverr = ent[8];
                    end else begin
                        m_prdata = '0;
                        m_pslverr = 0;
                    end
                    slv_busy = 0;
                end
            end else begin
                m_pready = 0; m_prdata = '0; m_pslverr = 0;
                if (!m_penable) slv_busy = 0;
            end
        end
    end

    // Event model: remembers which prefixes are outstanding, emits on a final byte.
    function automatic void model_byte(input logic [7:0] b);
        if (b == 8'h00) return;
        if (m_brk) begin
            if (b != 8'hE0 && b != 8'hF0) exp_q.push_back({1'b1, m_ext, b});
            m_brk = 0;
            m_ext = 0;
        end else if (m_ext) begin
            if (b == 8'hF0) m_brk = 1;
            else if (b != 8'hE0) begin
                exp_q.push_back({2'b01, b});
                m_ext = 0;
            end
        end else begin
            if (b == 8'hE0) m_ext = 1;
            else if (b == 8'hF0) m_brk = 1;
            else if (b != 8'hE1) exp_q.push_back({2'b00, b});
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got no response within the cycle budget, expected one", name);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        @(negedge clock);
        while (!(m_psel && m_penable && m_pready) && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 2000) fail_timeout(name);
    endtask

    task automatic measure_gap(output int g);
        g = 0;
        @(negedge clock);
        while (!m_psel && g < 300) begin
            g++;
            @(negedge clock);
        end
    endtask

    task automatic get_event(input string name, input logic [9:0] exp);
        int n = 0;
        while (!evt_valid && n < 3000) begin
            @(negedge clock);
            n++;
        end
        if (!evt_valid) fail_timeout(name);
        else begin
            check(name, 32'(evt_data), 32'(exp));
            evt_ready = 1;
            @(negedge clock);
            evt_ready = 0;
        end
    endtask

    task automatic wait_count(input int target, input string name);
        int n = 0;
        while (32'(evt_count) != target && n < 3000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 3000) fail_timeout(name);
    endtask

    task automatic quiesce();
        int n = 0;
        enable = 0;
        @(negedge clock);
        while (m_psel && n < 1000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 1000) fail_timeout("quiesce");
        repeat (2) @(negedge clock);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no end of test, expected one");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  g;
        int  n;
        bit  seen;
        bit  done;
        logic [7:0] bt;
        logic [9:0] exp_v;

        vecs[0] = '{32'h0000001C, 1, 10'h01C, "vec_make_1c"};
        vecs[1] = '{32'h00001CF0, 2, 10'h21C, "vec_break_1c"};
        vecs[2] = '{32'h0075F0E0, 3, 10'h375, "vec_ext_break_75"};
        vecs[3] = '{32'h000075E0, 2, 10'h175, "vec_ext_make_75"};
        vecs[4] = '{32'h000014E1, 2, 10'h014, "vec_e1_ignored"};
        vecs[5] = '{32'h001CE0F0, 3, 10'h01C, "vec_f0_e0_proto"};
        vecs[6] = '{32'h006BE0E0, 3, 10'h16B, "vec_e0_e0_repeat"};
        vecs[7] = '{32'h5AF0F0E0, 4, 10'h05A, "vec_e0f0_f0_drop"};
        vecs[8] = '{32'h0033F0F0, 3, 10'h033, "vec_f0_f0_proto"};
        vecs[9] = '{32'h0000E1E0, 2, 10'h1E1, "vec_e0_then_e1"};

        // Reset values
        repeat (3) @(negedge clock);
        check("rst_psel", 32'(m_psel), 0);
        check("rst_penable", 32'(m_penable), 0);
        check("rst_paddr", m_paddr, PS2_ADDR);
        check("rst_evt_valid", 32'(evt_valid), 0);
        check("rst_evt_count", 32'(evt_count), 0);
        check("rst_err_flag", 32'(err_flag), 0);
        check("rst_parser", 32'(dbg_parse_state), 0);
        check("tied_ctrl", 32'({m_pwrite, m_pprot, m_pstrb}), 0);
        check("tied_pwdata", m_pwdata, 0);
        reset_n = 1;
        @(negedge clock);

        // Single make code, latency and burst/idle poll spacing
        slv_q.push_back({1'b0, 8'h1C});
        enable = 1;
        wait_done("t1_first_read");
        @(negedge clock);
        check("t1_idle_after_read", 32'(m_psel), 0);
        check("t1_valid_latency", 32'(evt_valid), 0);
        @(negedge clock);
        check("t1_next_setup", 32'({m_psel, m_penable}), 32'b10);
        check("t1_evt_valid", 32'(evt_valid), 1);
        check("t1_evt_count", 32'(evt_count), 1);
        check("t1_evt_data", 32'(evt_data), 32'h01C);
        wait_done("t1_empty_read");
        measure_gap(g);
        check("t1_poll_interval", 32'(g), POLL_INTERVAL);
        get_event("t1_pop", 10'h01C);
        @(negedge clock);
        check("t1_count_after_pop", 32'(evt_count), 0);

        // Break prefix alone yields nothing until the code arrives
        slv_q.push_back({1'b0, 8'hF0});
        repeat (150) @(negedge clock);
        check("t2_f0_alone", 32'(evt_count), 0);
        check("t2_parser_f0", 32'(dbg_parse_state), 2);
        slv_q.push_back({1'b0, 8'h1C});
        get_event("t2_break_event", 10'h21C);

        // Scan-code vector table
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                bt = vecs[i].bytes[8*k +: 8];
                slv_q.push_back({1'b0, bt});
            end
            get_event(vecs[i].name, vecs[i].exp);
            repeat (3) @(negedge clock);
            check({vecs[i].name, "_count"}, 32'(evt_count), 0);
        end

        // Full FIFO back-pressure, no loss
        evt_ready = 0;
        for (int i = 0; i < 9; i++) slv_q.push_back({1'b0, 8'(8'h20 + i)});
        wait_count(EVT_DEPTH, "t4_fill");
        seen = 0;
        repeat (100) begin
            @(negedge clock);
            if (m_psel) seen = 1;
        end
        check("t4_full_no_poll", 32'(seen), 0);
        check("t4_ninth_held", 32'(slv_q.size()), 1);
        get_event("t4_head", 10'h020);
        wait_count(EVT_DEPTH, "t4_refill");
        check("t4_ninth_read", 32'(slv_q.size()), 0);
        for (int i = 1; i < 9; i++) get_event("t4_drain", 10'(8'h20 + i));
        @(negedge clock);
        check("t4_empty", 32'(evt_count), 0);

        // Slave error: byte discarded, sticky flag, interval, clear
        quiesce();
        slv_q.push_back({1'b1, 8'h1C});
        enable = 1;
        wait_done("t5_err_read");
        measure_gap(g);
        check("t5_err_gap", 32'(g), POLL_INTERVAL);
        check("t5_err_flag", 32'(err_flag), 1);
        check("t5_no_event", 32'(evt_count), 0);
        err_clr = 1;
        @(negedge clock);
        err_clr = 0;
        check("t5_err_clr", 32'(err_flag), 0);

        // enable drops mid-transfer: transfer completes, no further polls
        quiesce();
        slv_wait_lo = 4; slv_wait_hi = 4;
        slv_q.push_back({1'b0, 8'h2C});
        enable = 1;
        n = 0;
        while (!m_penable && n < 500) begin
            @(negedge clock);
            n++;
        end
        enable = 0;
        get_event("t_enfall_event", 10'h02C);
        seen = 0;
        repeat (100) begin
            @(negedge clock);
            if (m_psel) seen = 1;
        end
        check("t_enfall_no_poll", 32'(seen), 0);

        // Reset during a stalled access
        slv_wait_lo = 30; slv_wait_hi = 30;
        slv_q.push_back({1'b0, 8'h3C});
        slv_q.push_back({1'b0, 8'h4D});
        enable = 1;
        wait_count(1, "t_rst_first_event");
        n = 0;
        while (!m_penable && n < 500) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        check("t_rst_in_access", 32'(m_penable), 1);
        reset_n = 0;
        enable = 0;
        @(negedge clock);
        check("t_rst_psel", 32'({m_psel, m_penable}), 0);
        check("t_rst_count", 32'(evt_count), 0);
        check("t_rst_valid", 32'(evt_valid), 0);
        reset_n = 1;
        slv_q.delete();
        slv_wait_lo = 0; slv_wait_hi = 0;
        repeat (2) @(negedge clock);

`ifdef PS2_POLL_TIMEOUT_EN
        // Stalled slave aborts the access and resets the parser
        slv_q.push_back({1'b0, 8'hF0});
        enable = 1;
        n = 0;
        while (dbg_parse_state != 2'd2 && n < 500) begin
            @(negedge clock);
            n++;
        end
        check("to_parser_primed", 32'(dbg_parse_state), 2);
        check("to_err_before", 32'(err_flag), 0);
        slv_hang = 1;
        n = 0;
        while (!m_penable && n < 500) begin
            @(negedge clock);
            n++;
        end
        n = 0;
        while (m_psel && n < 1000) begin
            @(negedge clock);
            n++;
        end
        check("to_psel_drop", 32'(n), TIMEOUT);
        check("to_err_flag", 32'(err_flag), 1);
        check("to_parser_idle", 32'(dbg_parse_state), 0);
        slv_hang = 0;
        quiesce();
`endif

        // Randomized byte streams against the event model
        quiesce();
        m_ext = 0;
        m_brk = 0;
        slv_wait_lo = 0; slv_wait_hi = 2;
        for (int i = 0; i < 80; i++) begin
            int r;
            r = int'($urandom_range(99, 0));
            if (r < 4) bt = 8'h00;
            else if (r < 34) bt = (r < 22) ? 8'hE0 : 8'hF0;
            else if (r < 38) bt = 8'hE1;
            else bt = 8'($urandom_range(255, 1));
            if (r >= 4 && r < 8) begin
                slv_q.push_back({1'b1, bt});
            end else begin
                slv_q.push_back({1'b0, bt});
                model_byte(bt);
            end
        end
        enable = 1;
        n = 0;
        done = 0;
        while (n < 20000 && !done) begin
            @(negedge clock);
            n++;
            if (slv_q.size() == 0 && exp_q.size() == 0) begin
                evt_ready = 0;
                done = 1;
            end else begin
                evt_ready = 1'($urandom_range(1, 0));
                if (evt_valid && evt_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL rand_extra_event: got 0x%0h, expected no event", evt_data);
                    end else begin
                        exp_v = exp_q.pop_front();
                        check("rand_event", 32'(evt_data), 32'(exp_v));
                    end
                end
            end
        end
        if (!done) fail_timeout("rand_drain");
        repeat (10) @(negedge clock);
        check("rand_no_extra", 32'(evt_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
